// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB requester-port arbiter.
package apb_arb_pkg;

  // APB transfer sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Default ACCESS-phase watchdog limit (only meaningful with APB_ARB_TIMEOUT_EN)
  localparam int TIMEOUT_CYCLES_DEF = 256;

endpackage : apb_arb_pkg

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask),
// searching upward from ptr and wrapping at NUM_REQ-1 -> 0.
module apb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;

  assign cand = req & ~mask;

  // Walk offsets from farthest to nearest so the nearest candidate wins
  always_comb begin
    int                idx;
    logic [IDX_W-1:0]  sel;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = idx[IDX_W-1:0];
      if (cand[sel]) begin
        grant = sel;
        any   = 1'b1;
      end
    end
  end

endmodule : apb_rr_pick

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB requester port among NUM_REQ agents.
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      psel,
  output logic                      penable,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("apb_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;

  logic [IDX_W-1:0]    grant_inc;
  logic [IDX_W-1:0]    pick_ptr, pick_idx;
  logic [NUM_REQ-1:0]  pick_mask, grant_oh;
  logic                pick_any;
  logic                done_ok, done_to, done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oh
    assign grant_oh[gi] = (grant_q == IDX_W'(gi));
  end

  assign grant_inc = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // In ACCESS the next winner is searched from grant+1 with the current
  // grant excluded, so a back-to-back hand-off never re-picks the same agent.
  assign pick_ptr  = (state_q == ACCESS) ? grant_inc : rr_q;
  assign pick_mask = (state_q == ACCESS) ? grant_oh  : '0;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .grant (pick_idx),
    .any   (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;

  // A pready in the limit cycle wins, so the forced path requires pready low
  assign done_to = (state_q == ACCESS) && !pready && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog clears while in SETUP (entry to ACCESS) and counts stalled ACCESS cycles
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == SETUP) begin
      wdog_d = '0;
    end else if (state_q == ACCESS && !pready && !done_to) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  assign done_to = 1'b0;
`endif

  assign done_ok   = (state_q == ACCESS) && pready;
  assign done      = done_ok | done_to;
  assign req_done  = grant_oh & {NUM_REQ{done}};
  assign req_rdata = done_ok ? prdata : '0;
  assign req_err   = (done_ok & pslverr) | done_to;

  // Next-state: grant loading, SETUP/ACCESS sequencing and back-to-back hand-off
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (pick_any) begin
          grant_d  = pick_idx;
          paddr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          pwrite_d = req_write[pick_idx];
          pwdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          rr_d      = grant_inc;
          penable_d = 1'b0;
          if (pick_any) begin
            grant_d  = pick_idx;
            paddr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
            pwrite_d = req_write[pick_idx];
            pwdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered APB outputs; reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;

endmodule : apb_arbiter

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter (4 requesters, 32-bit).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_apb_arbiter;

  logic         clk = 1'b0;
  logic         nReset;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   req_write;
  logic [127:0] req_wdata;
  logic [3:0]   req_done;
  logic [31:0]  req_rdata;
  logic         req_err;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic         psel;
  logic         penable;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_arbiter #(
    .NUM_REQ        (4),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .req_err   (req_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  task automatic test_reset();
    nReset = 1'b0; req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctrl: got psel/penable/pwrite=%b expected 000", {psel, penable, pwrite});
    end
    vectors++;
    if (paddr !== 32'h0 || pwdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_bus: got paddr=%h pwdata=%h expected 0/0", paddr, pwdata);
    end
    vectors++;
    if (req_done !== 4'b0000) begin
      miscompares++; $display("FAIL reset_done: got %b expected 0000", req_done);
    end
    $display("reset: psel=%b penable=%b paddr=%h", psel, penable, paddr);
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_done;
    logic [31:0] exp_addr;
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h10 * (i + 1);
    req_write = 4'b0000;
    prdata = 32'hA5A5_0000;
    pready = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_addr = 32'h10 * ((t % 4) + 1);
      exp_done = 4'b0001 << (t % 4);
      @(negedge clk); #1;
      vectors++;
      if ({psel, penable} !== 2'b10 || paddr !== exp_addr) begin
        miscompares++;
        $display("FAIL fair_setup%0d: got psel/penable=%b paddr=%h expected 10 %h", t, {psel, penable}, paddr, exp_addr);
      end
      @(negedge clk); #1;
      vectors++;
      if (penable !== 1'b1 || req_done !== exp_done) begin
        miscompares++;
        $display("FAIL fair_grant%0d: got penable=%b req_done=%b expected 1 %b", t, penable, req_done, exp_done);
      end
      $display("fairness xfer %0d: paddr=%h req_done=%b", t, paddr, req_done);
      if (t == 7) req_valid = 4'b0000;
    end
    @(negedge clk); #1;
    vectors++;
    if (psel !== 1'b0 || req_done !== 4'b0000) begin
      miscompares++; $display("FAIL fair_idle: got psel=%b req_done=%b expected 0 0000", psel, req_done);
    end
    pready = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_addr[2*32 +: 32] = 32'h40; req_write[2] = 1'b0;
    req_valid = 4'b0100; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    vectors++;
    if ({psel, penable} !== 2'b10 || paddr !== 32'h40 || pwrite !== 1'b0 || req_done !== 4'b0000) begin
      miscompares++;
      $display("FAIL rd_setup: got psel/penable=%b paddr=%h pwrite=%b done=%b expected 10 00000040 0 0000", {psel, penable}, paddr, pwrite, req_done);
    end
    @(negedge clk); #1;
    vectors++;
    if ({psel, penable} !== 2'b11 || req_done !== 4'b0000) begin
      miscompares++; $display("FAIL rd_access: got psel/penable=%b done=%b expected 11 0000", {psel, penable}, req_done);
    end
    pready = 1'b1; #1;
    vectors++;
    if (req_done !== 4'b0100 || req_rdata !== 32'hDEAD_BEEF || req_err !== 1'b0) begin
      miscompares++; $display("FAIL rd_done: got done=%b rdata=%h err=%b expected 0100 deadbeef 0", req_done, req_rdata, req_err);
    end
    $display("single read: req_done=%b rdata=%h", req_done, req_rdata);
    @(negedge clk);
    req_valid = 4'b0000; pready = 1'b0; #1;
    vectors++;
    if (psel !== 1'b0 || req_done !== 4'b0000) begin
      miscompares++; $display("FAIL rd_idle: got psel=%b done=%b expected 0 0000", psel, req_done);
    end
  endtask

  task automatic test_wait_states();
    int pulses;
    pulses = 0;
    @(negedge clk);
    req_addr[0 +: 32] = 32'h100; req_write[0] = 1'b1; req_wdata[0 +: 32] = 32'h1234;
    req_valid = 4'b0001; pready = 1'b0; prdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    vectors++;
    if ({psel, penable} !== 2'b10) begin
      miscompares++; $display("FAIL ws_setup: got psel/penable=%b expected 10", {psel, penable});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) pready = 1'b1;
      #1;
      vectors++;
      if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h100 || pwdata !== 32'h1234) begin
        miscompares++;
        $display("FAIL ws_hold%0d: got ctrl=%b paddr=%h pwdata=%h expected 111 00000100 00001234", k, {psel, penable, pwrite}, paddr, pwdata);
      end
      if (req_done != 4'b0000) pulses++;
      vectors++;
      if (req_done !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        miscompares++; $display("FAIL ws_done%0d: got %b expected %b", k, req_done, (k == 3) ? 4'b0001 : 4'b0000);
      end
      $display("wait states access %0d: pready=%b req_done=%b", k, pready, req_done);
    end
    @(negedge clk);
    req_valid = 4'b0000; pready = 1'b0; #1;
    if (req_done != 4'b0000) pulses++;
    vectors++;
    if (psel !== 1'b0 || pulses != 1) begin
      miscompares++; $display("FAIL ws_after: got psel=%b pulses=%0d expected 0 1", psel, pulses);
    end
  endtask

  task automatic test_error();
    @(negedge clk);
    req_addr[3*32 +: 32] = 32'h300; req_write[3] = 1'b0;
    req_valid = 4'b1000; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_0BAD;
    @(negedge clk);
    @(negedge clk);
    pready = 1'b1; pslverr = 1'b1; #1;
    vectors++;
    if (req_done !== 4'b1000 || req_err !== 1'b1) begin
      miscompares++; $display("FAIL err_done: got done=%b err=%b expected 1000 1", req_done, req_err);
    end
    $display("error read: req_done=%b req_err=%b", req_done, req_err);
    @(negedge clk);
    req_addr[1*32 +: 32] = 32'h104; req_write[1] = 1'b0;
    req_valid = 4'b0010; pready = 1'b0; pslverr = 1'b0; prdata = 32'h600D_600D;
    @(negedge clk); #1;
    vectors++;
    if (psel !== 1'b1 || paddr !== 32'h104) begin
      miscompares++; $display("FAIL err_next_setup: got psel=%b paddr=%h expected 1 00000104", psel, paddr);
    end
    @(negedge clk);
    pready = 1'b1; #1;
    vectors++;
    if (req_done !== 4'b0010 || req_err !== 1'b0 || req_rdata !== 32'h600D_600D) begin
      miscompares++; $display("FAIL err_next_done: got done=%b err=%b rdata=%h expected 0010 0 600d600d", req_done, req_err, req_rdata);
    end
    $display("after error: req_done=%b req_err=%b", req_done, req_err);
    @(negedge clk);
    req_valid = 4'b0000; pready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_addr[2*32 +: 32] = 32'h200; req_valid = 4'b0100; pready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++;
    if (penable !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre: got penable=%b expected 1", penable);
    end
    #1 nReset = 1'b0; pready = 1'b1;
    #1;
    vectors++;
    if ({psel, penable} !== 2'b00 || req_done !== 4'b0000) begin
      miscompares++; $display("FAIL rst_mid: got psel/penable=%b done=%b expected 00 0000", {psel, penable}, req_done);
    end
    $display("reset mid-access: psel=%b penable=%b req_done=%b", psel, penable, req_done);
    req_valid = 4'b0000; pready = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    req_addr[1*32 +: 32] = 32'h110; req_addr[3*32 +: 32] = 32'h330;
    req_valid = 4'b1010; prdata = 32'h1111_2222;
    @(negedge clk); #1;
    vectors++;
    if (psel !== 1'b1 || paddr !== 32'h110) begin
      miscompares++; $display("FAIL rst_ptr: got psel=%b paddr=%h expected 1 00000110", psel, paddr);
    end
    @(negedge clk);
    pready = 1'b1; #1;
    vectors++;
    if (req_done !== 4'b0010) begin
      miscompares++; $display("FAIL rst_fresh_done: got %b expected 0010", req_done);
    end
    $display("fresh after reset: req_done=%b", req_done);
    @(negedge clk);
    req_valid = 4'b0000; pready = 1'b0;
    @(negedge clk);
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    req_addr[0 +: 32] = 32'h500; req_write[0] = 1'b0;
    req_valid = 4'b0001; pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (k < 8) begin
        if (req_done !== 4'b0000) begin
          miscompares++; $display("FAIL to_wait%0d: got done=%b expected 0000", k, req_done);
        end
      end else begin
        if (req_done !== 4'b0001 || req_err !== 1'b1 || req_rdata !== 32'h0) begin
          miscompares++; $display("FAIL to_forced: got done=%b err=%b rdata=%h expected 0001 1 00000000", req_done, req_err, req_rdata);
        end
      end
    end
    $display("timeout: req_done=%b req_err=%b rdata=%h", req_done, req_err, req_rdata);
    @(negedge clk);
    req_valid = 4'b0000; #1;
    vectors++;
    if ({psel, penable} !== 2'b00) begin
      miscompares++; $display("FAIL to_idle: got psel/penable=%b expected 00", {psel, penable});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_single_read();
    test_wait_states();
    test_error();
    test_reset_mid_access();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "bench time limit expired");
  end

endmodule : tb_apb_arbiter

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
Shares one APB requester port (PSEL/PENABLE/PADDR/...) between NUM_REQ on-chip requesters, e.g. the AHB-to-APB bridge plus DMA/debug agents.
- Round-robin grant.
- Sequences the APB SETUP/ACCESS phases.
- Returns completion, read data and error to the winning requester.
- Sits between the requesters and the APB subordinate decode/mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 256, ACCESS-phase watchdog limit; used only with APB_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
nReset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester transfer request
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_write  in  NUM_REQ  1=write, 0=read
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_done  out  NUM_REQ  one-hot completion strobe
req_rdata  out  DATA_W  read data, valid with req_done
req_err  out  1  error, valid with req_done
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
psel  out  1  APB select
penable  out  1  APB enable
pready  in  1  APB ready
prdata  in  DATA_W  APB read data
pslverr  in  1  APB error

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async, any time, including mid-transfer):
  - psel=0, penable=0, paddr=0, pwrite=0, pwdata=0.
  - State=IDLE, rr pointer=0, grant=0, watchdog=0.
  - Any in-flight transfer is abandoned with no req_done.
- Requester rule: hold req_valid, addr, write, wdata stable until req_done. The arbiter latches them at grant. A requester that drops early is ignored; its transfer still completes and still strobes req_done.
- Pick: first requester with req_valid=1, searching upward from rr pointer, wrapping at NUM_REQ-1 -> 0.
- FSM states:
  - IDLE: if any req_valid, register grant plus its addr/write/wdata onto paddr/pwrite/pwdata; psel<=1, penable<=0; -> SETUP. Otherwise stay; psel=0.
  - SETUP: penable<=1 -> ACCESS. Exactly one cycle.
  - ACCESS: hold outputs while pready=0. When pready=1:
    - Complete the transfer.
    - rr pointer <= (grant+1) mod NUM_REQ.
    - If another requester (current grant masked) has req_valid, load it and go directly to SETUP with psel=1, penable<=0 (back-to-back, no idle cycle).
    - Otherwise psel<=0, penable<=0 and go to IDLE.
- Completion (combinational):
  - req_done[grant] = (state==ACCESS) & pready.
  - req_rdata = prdata when done, else 0.
  - req_err = pslverr & done.
  - Write completions also drive req_rdata = prdata; requesters ignore it.
- Latency: a request seen in IDLE at cycle N gives psel at N+1, penable at N+2, earliest req_done at N+2.
- paddr/pwrite/pwdata are stable from SETUP through the completion cycle.
- Fairness: with all requesters asserted continuously, grants are 0,1,2,3,0,... Maximum wait is NUM_REQ-1 transfers.

Optional Feature:
APB_ARB_TIMEOUT_EN:
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES-1 with pready still low, the arbiter forces completion:
  - req_done[grant]=1, req_err=1, req_rdata=0.
  - Same next-state rules as a normal completion.
  - A pready arriving in that same cycle takes priority as a normal completion.
- Undefined: no counter, and the arbiter waits indefinitely for pready.

Decomposition:
- Package apb_arb_pkg: state_t enum {IDLE, SETUP, ACCESS}; localparam for the default TIMEOUT_CYCLES.
- Sub-module apb_rr_pick: combinational round-robin picker with inputs (req vector, pointer, mask) and outputs (grant index, any).

Test Plan:
- Single read: req_valid[2]=1, addr 0x40, pready=1 on first ACCESS, prdata 0xDEADBEEF -> psel at N+1, penable at N+2, req_done=4'b0100 with rdata 0xDEADBEEF at N+2.
- Wait states: write 0x1234 from req 0 with pready low 3 cycles -> paddr/pwdata stable 4 ACCESS cycles; single req_done pulse; psel low afterwards.
- Fairness: all 4 requesters held valid for 8 transfers -> grant order 0,1,2,3,0,1,2,3; back-to-back SETUP with no IDLE cycles between them.
- Error: pslverr=1 with pready on req 3 read -> req_err=1 coincident with req_done[3]; next transfer unaffected.
- Reset mid-ACCESS: deassert nReset while penable=1 -> psel/penable 0 immediately, no req_done; a fresh request after release is granted from pointer 0.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready held low -> forced req_done with req_err=1, rdata 0 after 8 ACCESS cycles; arbiter then returns to IDLE.
